// File: rtl/sdp_sync_ram.sv
// Simple-dual-port synchronous RAM: one write port with per-lane enables,
// one read port with 1- or 2-cycle registered latency and a read-valid
// strobe. Same-address read-during-write returns either the old word or the
// merged (write-through) word, selected by RDW_MODE.
module sdp_sync_ram #(
  parameter  int ADDR_SIZE    = 10,
  parameter  int WORD_SIZE    = 8,
  parameter  int LANE_WIDTH   = 8,
  parameter  int READ_LATENCY = 1,
  parameter  int RDW_MODE     = 0,
  localparam int NUM_LANES    = WORD_SIZE / LANE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [NUM_LANES-1:0] wbe,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 rvalid
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  // Parameter legality is checked at elaboration so a bad instance never builds.
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sdp_sync_ram: READ_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
    $error("sdp_sync_ram: RDW_MODE must be 0 or 1");
  end
  if ((WORD_SIZE % LANE_WIDTH) != 0) begin : g_bad_lanes
    $error("sdp_sync_ram: WORD_SIZE must be a multiple of LANE_WIDTH");
  end

  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic                 wr_en;
  logic                 rd_en;
  logic                 same_addr;
  logic [WORD_SIZE-1:0] rd_old;
  logic [WORD_SIZE-1:0] rd_word;

  // Port qualification and the array-stage read word, including the
  // write-through merge when a same-address write lands on the same edge.
  always_comb begin
    wr_en     = !rst && cs && we;
    rd_en     = !rst && cs && re;
    same_addr = (waddr == raddr);
    rd_old    = mem[raddr];
    rd_word   = rd_old;
    if (RDW_MODE == 1 && wr_en && same_addr) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wbe[i]) begin
          rd_word[i*LANE_WIDTH +: LANE_WIDTH] = wdata[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Lane-masked array write; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wbe[i]) begin
          mem[waddr][i*LANE_WIDTH +: LANE_WIDTH] <= wdata[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    logic [WORD_SIZE-1:0] rdata_d;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 rvalid_d;
    logic                 rvalid_q;

    // Output register loads on an accepted read and holds otherwise.
    always_comb begin
      rdata_d  = rd_en ? rd_word : rdata_q;
      rvalid_d = rd_en;
    end

    // Output register with synchronous clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end else begin : g_lat2
    logic [WORD_SIZE-1:0] stage_data_d;
    logic [WORD_SIZE-1:0] stage_data_q;
    logic                 stage_valid_d;
    logic                 stage_valid_q;
    logic [WORD_SIZE-1:0] rdata_d;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 rvalid_d;
    logic                 rvalid_q;

    // Array stage captures the (collision-resolved) word; the output stage
    // only forwards it, so a later write cannot disturb a captured word.
    always_comb begin
      stage_data_d  = rd_en ? rd_word : stage_data_q;
      stage_valid_d = rd_en;
      rdata_d       = stage_valid_q ? stage_data_q : rdata_q;
      rvalid_d      = stage_valid_q;
    end

    // Both pipeline stages clear on reset, dropping any read in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_data_q  <= '0;
        stage_valid_q <= 1'b0;
        rdata_q       <= '0;
        rvalid_q      <= 1'b0;
      end else begin
        stage_data_q  <= stage_data_d;
        stage_valid_q <= stage_valid_d;
        rdata_q       <= rdata_d;
        rvalid_q      <= rvalid_d;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

endmodule

// File: tb/tb_sdp_sync_ram.sv
// Bench for sdp_sync_ram: four instances (latency 1/2 x RDW old/new) share
// one stimulus stream; a reference memory and two expected-read queues
// (one per latency) predict every output cycle.
module tb_sdp_sync_ram;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int LW = 8;
  localparam int NL = DW / LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [NL-1:0] wbe;
  logic          re;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata_w [4];
  logic [3:0]    rvalid_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sdp_sync_ram #(
      .ADDR_SIZE   (AW),
      .WORD_SIZE   (DW),
      .LANE_WIDTH  (LW),
      .READ_LATENCY(1 + g / 2),
      .RDW_MODE    (g % 2)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .cs    (cs),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .wbe   (wbe),
      .re    (re),
      .raddr (raddr),
      .rdata (rdata_w[g]),
      .rvalid(rvalid_w[g])
    );
  end

  typedef struct {
    int            due;
    logic [DW-1:0] d_old;
    logic [DW-1:0] d_new;
  } exp_t;

  exp_t          q_l1 [$];
  exp_t          q_l2 [$];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] held [4];
  int            cyc = 0;
  bit            armed = 0;
  bit            rst_edge = 0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model at the clock edge, then output checks 1 time unit later.
  exp_t          e;
  logic [DW-1:0] old_w;
  logic [DW-1:0] new_w;
  bit            hit;
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      armed    = 1;
      rst_edge = 1;
      q_l1.delete();
      q_l2.delete();
    end else begin
      rst_edge = 0;
      if (cs && re) begin
        old_w = ref_mem[raddr];
        new_w = old_w;
        if (we && waddr == raddr) begin
          for (int i = 0; i < NL; i++)
            if (wbe[i]) new_w[i*LW +: LW] = wdata[i*LW +: LW];
        end
        q_l1.push_back('{cyc, old_w, new_w});
        q_l2.push_back('{cyc + 1, old_w, new_w});
      end
      if (cs && we) begin
        for (int i = 0; i < NL; i++)
          if (wbe[i]) ref_mem[waddr][i*LW +: LW] = wdata[i*LW +: LW];
      end
    end
    #1;
    if (armed) begin
      for (int li = 0; li < 2; li++) begin
        hit = 0;
        if (li == 0 && q_l1.size() > 0 && q_l1[0].due == cyc) begin
          hit = 1;
          e = q_l1.pop_front();
        end
        if (li == 1 && q_l2.size() > 0 && q_l2[0].due == cyc) begin
          hit = 1;
          e = q_l2.pop_front();
        end
        for (int m = 0; m < 2; m++) begin
          int g;
          g = 2 * li + m;
          if (rst_edge) held[g] = '0;
          if (hit) begin
            held[g] = (m == 1) ? e.d_new : e.d_old;
            chk($sformatf("u%0d_rvalid", g), {15'd0, rvalid_w[g]}, 16'd1);
          end else begin
            chk($sformatf("u%0d_rvalid", g), {15'd0, rvalid_w[g]}, 16'd0);
          end
          chk($sformatf("u%0d_rdata", g), rdata_w[g], held[g]);
        end
      end
    end
  end

  task automatic drive(input bit r, input bit c, input bit w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [NL-1:0] be,
                       input bit rr, input logic [AW-1:0] ra);
    rst = r; cs = c; we = w; waddr = wa; wdata = wd; wbe = be; re = rr; raddr = ra;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, '0, '0, '0, 0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] be);
    drive(0, 1, 1, a, d, be, 0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(0, 1, 0, '0, '0, '0, 1, a);
  endtask

  initial begin
    rst = 1; cs = 0; we = 0; waddr = '0; wdata = '0; wbe = '0; re = 0; raddr = '0;
    @(negedge clk);
    drive(1, 1, 0, '0, '0, '0, 0, '0);
    drive(1, 1, 0, '0, '0, '0, 0, '0);

    // Fill every word so the model never predicts an unknown.
    for (int a = 0; a < 16; a++) wr(a[AW-1:0], 16'h1000 + 16'(a) * 16'h0101, 2'b11);
    wr(4'd3, 16'hBEEF, 2'b11);

    // Random traffic (collisions and cs gaps included), avoiding addr 3.
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] wa;
      wa = AW'($urandom_range(0, 15));
      if (wa == 4'd3) wa = 4'd4;
      drive(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), wa,
            16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 15)));
    end

    // Reset with active requests underneath: they must be ignored.
    drive(1, 1, 1, 4'd3, 16'h0000, 2'b11, 1, 4'd3);
    drive(1, 1, 1, 4'd3, 16'h0000, 2'b11, 1, 4'd3);
    rd(4'd3);
    idle(3);

    // Latency.
    wr(4'd5, 16'h1234, 2'b11);
    rd(4'd5);
    idle(3);

    // Byte enables.
    wr(4'd2, 16'hAAAA, 2'b11);
    wr(4'd2, 16'h5566, 2'b01);
    rd(4'd2);
    wr(4'd2, 16'hFFFF, 2'b00);
    rd(4'd2);
    idle(3);

    // Same-address collision, then a clean follow-up read.
    wr(4'd7, 16'h0F0F, 2'b11);
    drive(0, 1, 1, 4'd7, 16'hF0F0, 2'b10, 1, 4'd7);
    rd(4'd7);
    idle(3);

    // Streaming, then streaming with chip-select holes.
    for (int a = 0; a < 16; a++) rd(a[AW-1:0]);
    idle(3);
    for (int a = 0; a < 16; a++) drive(0, !(a == 4 || a == 9), 0, '0, '0, '0, 1, a[AW-1:0]);
    idle(3);

    // Reset right behind an accepted read, with a write in the reset cycle.
    rd(4'd1);
    drive(1, 1, 1, 4'd1, 16'hDEAD, 2'b11, 0, '0);
    idle(2);
    rd(4'd1);
    idle(4);

    chk("drain_l1", 16'(q_l1.size()), 16'd0);
    chk("drain_l2", 16'(q_l2.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1, "timeout");
  end

endmodule
